// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared constants and types for the instruction-fetch stage:
//   memory direction encodings, default memory window, fetch state
//   encoding, the FIFO entry layout and a window/alignment helper.
// -----------------------------------------------------------------------------
package fetch_pkg;

    // Memory read_write encodings.
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Default fetch window.
    localparam logic [31:0] DEFAULT_START_ADDR = 32'h0100_0000;
    localparam logic [31:0] DEFAULT_MEM_BYTES  = 32'h0010_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        ERROR = 1'b1
    } fetch_state_e;

    // One buffered fetch: the PC and the word read from it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    localparam int FIFO_ENTRY_W = $bits(fifo_entry_t);

    // True when addr is word aligned and inside [start, start+bytes-4].
    // Done in 33 bits so a window touching the top of the address space
    // does not wrap.
    function automatic logic addr_fetchable(
        input logic [31:0] addr,
        input logic [31:0] start,
        input logic [31:0] bytes
    );
        logic [32:0] last;
        last = {1'b0, start} + {1'b0, bytes} - 33'd4;
        return (addr[1:0] == 2'b00)
            && ({1'b0, addr} >= {1'b0, start})
            && ({1'b0, addr} <= last);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles the fetch stage's memory port, decode handshake, redirect input
//   and error flag.
//   master: the fetch stage (drives memory address, instruction outputs).
//   slave : the surroundings (memory read data, decode ready, redirects).
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    // Main-memory side
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    // Decode side
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    // Control-flow redirect and status
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_error;

    modport master (
        output mem_address, mem_read_write, mem_data_out,
        input  mem_data_in,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output fetch_error
    );

    modport slave (
        input  mem_address, mem_read_write, mem_data_out,
        output mem_data_in,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  fetch_error
    );
endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous DEPTH-entry FIFO of {pc, inst} pairs.
//   Ports:
//     clock, reset  - rising-edge clock, synchronous active-high reset
//     flush         - empty the FIFO; wins over push and pop
//     push, push_entry - write an entry (accepted if room or popping)
//     pop           - drop the head entry (ignored when empty)
//     count         - number of valid entries
//     head_valid    - count != 0
//     head          - head entry from storage, zero while empty
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  fifo_entry_t       push_entry,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic              head_valid,
    output fifo_entry_t       head
);

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        do_pop   = pop && (count_q != '0) && !flush;
        do_push  = push && ((count_q < CNT_W'(DEPTH)) || do_pop) && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so
    // stale contents are never visible and the array maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head       = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage in front of main memory. Owns the PC, reads the
//   word at PC combinationally from memory, buffers {pc, inst} in a small
//   FIFO and hands entries to decode over valid/ready. Redirects flush the
//   buffer and load a new PC; fetching past the window or redirecting to a
//   misaligned/out-of-window target enters a sticky ERROR state.
//   Ports:
//     clock, reset - rising-edge clock, synchronous active-high reset
//     bus          - fetch_stage_if.master: memory port, decode handshake,
//                    redirect input and fetch_error flag
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] START_ADDR = DEFAULT_START_ADDR,
    parameter logic [31:0] MEM_BYTES  = DEFAULT_MEM_BYTES,
    parameter int          DEPTH      = 2
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam int          CNT_W     = $clog2(DEPTH + 1);
    localparam logic [32:0] LAST_ADDR = {1'b0, START_ADDR} + {1'b0, MEM_BYTES} - 33'd4;

    logic [31:0]  pc_q, pc_d;
    fetch_state_e state_q, state_d;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_head_valid;
    logic             fifo_push, fifo_pop, fifo_flush;
    fifo_entry_t      push_entry, fifo_head;

    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        fifo_pop   = fifo_head_valid && bus.inst_ready;
        push_entry = '{pc: pc_q, inst: bus.mem_data_in};

        if (bus.redirect_valid) begin
            // The flush wins inside the FIFO, so a same-cycle pop is dropped.
            fifo_flush = 1'b1;
            pc_d       = bus.redirect_pc;
            if (!addr_fetchable(bus.redirect_pc, START_ADDR, MEM_BYTES)) begin
                state_d = ERROR;
            end
        end else if ((state_q == FETCH)
                     && ((fifo_count < CNT_W'(DEPTH)) || fifo_pop)) begin
            fifo_push = 1'b1;
            pc_d      = pc_q + 32'd4;
            // The last word of the window is still fetched; what follows is not.
            if (({1'b0, pc_q} + 33'd4) > LAST_ADDR) begin
                state_d = ERROR;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= START_ADDR;
            state_q <= FETCH;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (fifo_flush),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .count      (fifo_count),
        .head_valid (fifo_head_valid),
        .head       (fifo_head)
    );

    assign bus.mem_address    = pc_q;
    assign bus.mem_read_write = READ;
    assign bus.mem_data_out   = '0;
    assign bus.inst_valid     = fifo_head_valid;
    assign bus.inst           = fifo_head.inst;
    assign bus.inst_pc        = fifo_head.pc;
    assign bus.fetch_error    = (state_q == ERROR);

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A memory function supplies read
//   data; a queue-based model of the fetch buffer predicts the outputs.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] START = 32'h0100_0000;
    localparam logic [31:0] BYTES = 32'h0010_0000;
    localparam int          DEPTH = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fetch_stage_if bus();

    fetch_stage #(
        .START_ADDR (START),
        .MEM_BYTES  (BYTES),
        .DEPTH      (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- memory contents ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == START)              return 32'h0000_0013;
        if (a == START + 32'd4)      return 32'h0010_0093;
        if (a == START + 32'd8)      return 32'h0020_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    assign bus.mem_data_in = mem_word(bus.mem_address);

    // ---------------- reference model ----------------
    fifo_entry_t  m_q[$];
    logic [31:0]  m_pc = START;
    bit           m_err = 1'b0;
    logic [31:0]  consumed[$];

    function automatic bit tb_fetchable(input logic [31:0] a);
        longint ua, lo, hi;
        ua = {32'd0, a};
        lo = {32'd0, START};
        hi = lo + {32'd0, BYTES} - 4;
        return (a[1:0] == 2'b00) && (ua >= lo) && (ua <= hi);
    endfunction

    // Advance the model across one rising edge using the driven inputs.
    function automatic void model_edge();
        bit     pop;
        longint hi;
        hi = {32'd0, START} + {32'd0, BYTES} - 4;
        if (reset) begin
            m_q.delete();
            m_pc  = START;
            m_err = 1'b0;
            return;
        end
        pop = (m_q.size() != 0) && bus.inst_ready;
        if (bus.redirect_valid) begin
            m_q.delete();
            m_pc = bus.redirect_pc;
            if (!tb_fetchable(bus.redirect_pc)) m_err = 1'b1;
            return;
        end
        if (pop) void'(m_q.pop_front());
        if (!m_err && (m_q.size() < DEPTH)) begin
            m_q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
            if ({32'd0, m_pc} + 4 > hi) m_err = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endfunction

    // {inst_valid, inst, inst_pc, fetch_error, mem_address}
    function automatic logic [97:0] exp_vec();
        logic [31:0] hi, hp;
        logic        v;
        v  = (m_q.size() != 0);
        hi = '0;
        hp = '0;
        if (v) begin
            hi = m_q[0].inst;
            hp = m_q[0].pc;
        end
        return {v, hi, hp, logic'(m_err), m_pc};
    endfunction

    function automatic logic [97:0] dut_vec();
        return {bus.inst_valid, bus.inst, bus.inst_pc, bus.fetch_error, bus.mem_address};
    endfunction

    // One clock: update model, record a real consumption, sample #1 later.
    task automatic cycle();
        if (!reset && !bus.redirect_valid && bus.inst_valid && bus.inst_ready)
            consumed.push_back(bus.inst_pc);
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset              = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        cycle();
        cycle();
        n_checks++;
        if (bus.mem_read_write !== READ || bus.mem_data_out !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_mem_ctrl: rw=%b dout=%h want rw=0 dout=0", bus.mem_read_write, bus.mem_data_out);
        end
        n_checks++;
        if ({bus.inst_valid, bus.inst, bus.inst_pc, bus.fetch_error} !== 66'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: valid=%b inst=%h pc=%h err=%b want all 0",
                     bus.inst_valid, bus.inst, bus.inst_pc, bus.fetch_error);
        end
        n_checks++;
        if (bus.mem_address !== START) begin
            n_errors++;
            $display("FAIL reset_pc: got %h want %h", bus.mem_address, START);
        end
    endtask

    task automatic test_stream();
        logic [31:0] words [3];
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        words[2] = 32'h0020_0113;
        reset          = 1'b0;
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL stream_model[%0d]: got %h want %h", k, dut_vec(), exp_vec());
            end
            if (k < 3) begin
                n_checks++;
                if (bus.inst_valid !== 1'b1 || bus.inst_pc !== START + 32'(4 * k)
                    || bus.inst !== words[k] || bus.mem_read_write !== READ) begin
                    n_errors++;
                    $display("FAIL stream_word[%0d]: valid=%b pc=%h inst=%h rw=%b want 1 %h %h 0",
                             k, bus.inst_valid, bus.inst_pc, bus.inst, bus.mem_read_write,
                             START + 32'(4 * k), words[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (5) begin
            cycle();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL backpressure_model: got %h want %h", dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (bus.mem_address !== START + 32'd8 || bus.inst !== 32'h0000_0013 || bus.inst_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure_hold: addr=%h inst=%h valid=%b want %h 00000013 1",
                     bus.mem_address, bus.inst, bus.inst_valid, START + 32'd8);
        end
        consumed.delete();
        bus.inst_ready = 1'b1;
        repeat (6) begin
            cycle();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL release_model: got %h want %h", dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (consumed.size() != 6) begin
            n_errors++;
            $display("FAIL release_count: got %0d want 6", consumed.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (consumed[i] !== START + 32'(4 * i)) begin
                    n_errors++;
                    $display("FAIL release_order[%0d]: got %h want %h", i, consumed[i], START + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (3) cycle();
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0100_0040;
        cycle();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.inst_valid !== 1'b0 || bus.mem_address !== 32'h0100_0040) begin
            n_errors++;
            $display("FAIL redirect_flush: valid=%b addr=%h want 0 01000040", bus.inst_valid, bus.mem_address);
        end
        consumed.delete();
        cycle();
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0100_0040 || bus.inst !== mem_word(32'h0100_0040)) begin
            n_errors++;
            $display("FAIL redirect_target: valid=%b pc=%h inst=%h want 1 01000040 %h",
                     bus.inst_valid, bus.inst_pc, bus.inst, mem_word(32'h0100_0040));
        end
        repeat (4) cycle();
        foreach (consumed[i]) begin
            n_checks++;
            if (consumed[i] < 32'h0100_0040) begin
                n_errors++;
                $display("FAIL redirect_stale[%0d]: got %h want >= 01000040", i, consumed[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0100_0042;
        cycle();
        bus.redirect_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if ({bus.fetch_error, bus.inst_valid, bus.mem_address} !== {1'b1, 1'b0, 32'h0100_0042}) begin
                n_errors++;
                $display("FAIL misaligned_hold[%0d]: err=%b valid=%b addr=%h want 1 0 01000042",
                         k, bus.fetch_error, bus.inst_valid, bus.mem_address);
            end
            bus.inst_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        reset = 1'b1;
        cycle();
        n_checks++;
        if (bus.fetch_error !== 1'b0 || bus.mem_address !== START) begin
            n_errors++;
            $display("FAIL misaligned_reset: err=%b addr=%h want 0 %h", bus.fetch_error, bus.mem_address, START);
        end
        reset          = 1'b0;
        bus.inst_ready = 1'b1;
        cycle();
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== START) begin
            n_errors++;
            $display("FAIL misaligned_restart: valid=%b pc=%h want 1 %h", bus.inst_valid, bus.inst_pc, START);
        end
    endtask

    task automatic test_window();
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0110_0000;
        cycle();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.fetch_error !== 1'b1) begin
            n_errors++;
            $display("FAIL window_outside: err=%b want 1", bus.fetch_error);
        end
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h010F_FFF8;
        cycle();
        bus.redirect_valid = 1'b0;
        cycle();
        n_checks++;
        if ({bus.inst_valid, bus.inst_pc, bus.fetch_error} !== {1'b1, 32'h010F_FFF8, 1'b0}) begin
            n_errors++;
            $display("FAIL window_penultimate: valid=%b pc=%h err=%b want 1 010ffff8 0",
                     bus.inst_valid, bus.inst_pc, bus.fetch_error);
        end
        cycle();
        n_checks++;
        if ({bus.inst_valid, bus.inst_pc, bus.fetch_error, bus.mem_address}
            !== {1'b1, 32'h010F_FFFC, 1'b1, 32'h0110_0000}) begin
            n_errors++;
            $display("FAIL window_last: valid=%b pc=%h err=%b addr=%h want 1 010ffffc 1 01100000",
                     bus.inst_valid, bus.inst_pc, bus.fetch_error, bus.mem_address);
        end
        cycle();
        n_checks++;
        if (bus.inst_valid !== 1'b0 || bus.fetch_error !== 1'b1) begin
            n_errors++;
            $display("FAIL window_drained: valid=%b err=%b want 0 1", bus.inst_valid, bus.fetch_error);
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (2) cycle();
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.mem_address !== START + 32'd8) begin
            n_errors++;
            $display("FAIL rstprio_fill: valid=%b addr=%h want 1 %h", bus.inst_valid, bus.mem_address, START + 32'd8);
        end
        reset              = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0100_0100;
        cycle();
        n_checks++;
        if ({bus.inst_valid, bus.mem_address, bus.fetch_error} !== {1'b0, START, 1'b0}) begin
            n_errors++;
            $display("FAIL rstprio_result: valid=%b addr=%h err=%b want 0 %h 0",
                     bus.inst_valid, bus.mem_address, bus.fetch_error, START);
        end
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            bus.inst_ready     = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = 1'b0;
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = START + 32'(4 * $urandom_range(0, 63));
            end else if (r < 10) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = START + BYTES - 32'(4 * $urandom_range(1, 4));
            end else if (r < 12) begin
                bus.redirect_valid = 1'b1;
                case ($urandom_range(0, 2))
                    0:       bus.redirect_pc = START + 32'd2;
                    1:       bus.redirect_pc = START - 32'd4;
                    default: bus.redirect_pc = START + BYTES;
                endcase
            end
            reset = ($urandom_range(0, 99) == 0);
            cycle();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL random_model[%0d]: got %h want %h", k, dut_vec(), exp_vec());
            end
        end
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_window();
        test_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of main memory; owns the PC.
- Drives the memory address and read_write ports and captures the combinational read data as the fetched instruction.
- Buffers fetched {pc, inst} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects, which flush the buffer.

Parameters:
- START_ADDR, 32'h01000000, reset PC and base address of the memory window.
- MEM_BYTES, 32'h00100000, size of the fetchable window in bytes.
- DEPTH, 2, FIFO entries (≥1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_address  out  32  byte address to main memory; equals pc.
- mem_read_write  out  1  constant READ (0).
- mem_data_out  out  32  write data to memory; constant 0.
- mem_data_in  in  32  combinational read data from memory for mem_address.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_ready  in  1  decode accepts head this cycle.
- inst  out  32  head instruction word.
- inst_pc  out  32  PC of head instruction.
- redirect_valid  in  1  load new PC this cycle.
- redirect_pc  in  32  redirect target.
- fetch_error  out  1  sticky fault flag.

Behaviour:
- Reset, sampled on the clock edge while reset=1:
  - pc=START_ADDR; FIFO emptied (count=0, pointers 0); state=FETCH; fetch_error=0.
  - inst_valid=0; inst and inst_pc read as 0 while empty.
  - Reset asserted mid-operation discards all buffered entries; it takes priority over redirect.
- States:
  - FETCH: normal operation.
  - ERROR: no pushes; pc frozen; FIFO drains normally; fetch_error=1.
  - Exit from ERROR: reset only.
- FETCH, per cycle, with pop = inst_valid && inst_ready:
  - Push {pc, mem_data_in} when (count<DEPTH) || pop; on push, pc <= pc+4 (32-bit, modulo 2^32).
  - Full with no pop: pc holds, no push; mem_address stays stable.
  - Simultaneous push and pop on a full FIFO: both happen; count unchanged.
- Latency: the word at address A appears on inst one cycle after the edge at which A is pushed. First instruction (pc=START_ADDR) is valid in the first cycle after reset deasserts +1 edge.
- Redirect (redirect_valid=1, not in reset) has priority over push and pop:
  - FIFO flushed (count=0).
  - The same-cycle pop is considered not consumed; decode must ignore it.
  - No push.
  - pc <= redirect_pc.
  - If redirect_pc[1:0]!=0, or redirect_pc is outside [START_ADDR, START_ADDR+MEM_BYTES-4]: pc <= redirect_pc anyway, state -> ERROR.
  - Redirect in ERROR: flushes the FIFO; state remains ERROR.
- Sequential overflow: if pc+4 would exceed START_ADDR+MEM_BYTES-4 after a push, the push of the last word still occurs, then state -> ERROR with pc = last+4.
- inst_valid = (count!=0). inst and inst_pc come from the FIFO head, registered storage only; no combinational path from mem_data_in to inst.
- mem_read_write=0 and mem_data_out=0 always, including during reset.

Decomposition:
- Package fetch_pkg:
  - READ=0 and WRITE=1 constants.
  - Default START_ADDR and MEM_BYTES.
  - Fetch state enum {FETCH, ERROR}.
  - Struct/width constant for a FIFO entry {pc[31:0], inst[31:0]}.
- Sub-module fetch_fifo:
  - Synchronous DEPTH-entry FIFO with push, pop, flush, count, head outputs.
  - Flush has priority over push and pop.

Test Plan:
- Reset then inst_ready=1 continuously, memory preloaded with words 0x00000013, 0x00100093, 0x00200113 -> one instruction per cycle with inst_pc 0x01000000, 0x01000004, 0x01000008 in order; mem_read_write=0 throughout.
- Backpressure: inst_ready=0 for 5 cycles after reset -> count saturates at 2, mem_address holds at 0x01000008, inst stays 0x00000013. Release -> 0x01000000 through 0x01000008 delivered in order, none skipped or duplicated.
- Redirect with FIFO full and inst_ready=1: redirect_pc=0x01000040 -> next cycle inst_valid=0. Following cycle inst_pc=0x01000040. Earlier buffered entries never appear.
- Misaligned redirect_pc=0x01000042 -> fetch_error=1 next cycle; no further pushes; remains set until reset. Reset -> fetch_error=0, inst_pc restarts at 0x01000000.
- Out-of-window redirect to 0x01100000 -> ERROR. Sequential fetch reaching 0x010FFFFC -> that word is delivered, then fetch_error=1.
- Reset asserted while FIFO holds 2 entries and redirect_valid=1 -> after the edge inst_valid=0, pc=0x01000000, fetch_error=0.
